regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_wb_fifo2.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned REG_COUNT     = 32;
    localparam int unsigned WB_FIFO_DEPTH = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    // Register 0 is hardwired; writes to it are discarded.
    function automatic logic is_r0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo2.sv
// Small FIFO holding pending load-return writebacks (addr+data payload).
module wb_fifo2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(WB_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(WB_FIFO_DEPTH + 1);

    logic [W-1:0]     store [WB_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = count == CNT_W'(WB_FIFO_DEPTH);
        empty   = count == '0;
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        rdata   = store[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Payload storage needs no reset: validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-return writebacks onto one register-file write port,
// with starvation protection for loads and a pending-load hazard scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned bit_size     = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [bit_size-1:0]   alu_data,
    output logic                  alu_stall,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [bit_size-1:0]   mem_data,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr_1,
    input  logic [REG_ADDR_W-1:0] chk_addr_2,
    output logic                  hazard_1,
    output logic                  hazard_2,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_addr,
    output logic [bit_size-1:0]   Write_data
);

    localparam int unsigned ENT_W = REG_ADDR_W + bit_size;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ENT_W-1:0]     head;
    reg_addr_t            head_addr;
    logic [bit_size-1:0]  head_data;
    logic                 alu_acc;
    wb_src_e              wb_src;
    logic [CNT_W-1:0]     starve_cnt;
    logic [CNT_W-1:0]     starve_cnt_nxt;
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nxt;

    wb_fifo2 #(.W(ENT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({mem_addr, mem_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration: ALU first, unless the queued load has waited too long.
    always_comb begin
        head_addr      = head[ENT_W-1 -: REG_ADDR_W];
        head_data      = head[bit_size-1:0];
        alu_stall      = starve_cnt == CNT_W'(STARVE_LIMIT);
        mem_ready      = ~fifo_full;
        alu_acc        = alu_valid & ~alu_stall;
        fifo_pop       = ~fifo_empty & ~alu_acc;
        fifo_push      = mem_valid & ~fifo_full;
        starve_cnt_nxt = (fifo_empty | fifo_pop) ? '0 : starve_cnt + CNT_W'(1);

        wb_src = WB_NONE;
        if (alu_acc && !is_r0(alu_addr)) begin
            wb_src = WB_ALU;
        end else if (fifo_pop && !is_r0(head_addr)) begin
            wb_src = WB_MEM;
        end

        // Clear before set so a same-cycle issue to the same register wins.
        pending_nxt = pending;
        if (fifo_pop)    pending_nxt[head_addr]  = 1'b0;
        if (issue_valid) pending_nxt[issue_addr] = 1'b1;
        pending_nxt[0] = 1'b0;

        hazard_1 = pending[chk_addr_1];
        hazard_2 = pending[chk_addr_2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            pending    <= '0;
            RegWrite   <= 1'b0;
            Write_addr <= '0;
            Write_data <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            pending    <= pending_nxt;
            RegWrite   <= wb_src != WB_NONE;
            case (wb_src)
                WB_ALU: begin
                    Write_addr <= alu_addr;
                    Write_data <= alu_data;
                end
                WB_MEM: begin
                    Write_addr <= head_addr;
                    Write_data <= head_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned SL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid, mem_valid, issue_valid;
    logic [4:0]    alu_addr, mem_addr, issue_addr, chk_addr_1, chk_addr_2;
    logic [BW-1:0] alu_data, mem_data;
    logic          alu_stall, mem_ready, hazard_1, hazard_2, RegWrite;
    logic [4:0]    Write_addr;
    logic [BW-1:0] Write_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.bit_size(BW), .STARVE_LIMIT(SL)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .hazard_1   (hazard_1),
        .hazard_2   (hazard_2),
        .RegWrite   (RegWrite),
        .Write_addr (Write_addr),
        .Write_data (Write_data)
    );

    typedef struct {
        logic [4:0]    a;
        logic [BW-1:0] d;
    } ent_t;

    int            checks = 0;
    int            errors = 0;
    ent_t          q[$];
    int            wait_cnt;
    bit [31:0]     pend;
    bit            exp_rw;
    logic [4:0]    exp_wa;
    logic [BW-1:0] exp_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wait_cnt = 0;
        pend     = '0;
        exp_rw   = 1'b0;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic rand_inputs();
        alu_valid   = $urandom_range(0, 9) < 6;
        alu_addr    = 5'($urandom);
        alu_data    = BW'($urandom);
        mem_valid   = $urandom_range(0, 9) < 5;
        mem_addr    = 5'($urandom);
        mem_data    = BW'($urandom);
        issue_valid = $urandom_range(0, 9) < 3;
        issue_addr  = 5'($urandom);
        chk_addr_1  = 5'($urandom);
        chk_addr_2  = ($urandom_range(0, 1) == 0) ? mem_addr : 5'($urandom);
    endtask

    // Compare DUT against the model for this cycle, then advance the model past the edge.
    task automatic step();
        bit   stall, ready, acc, pop, pre_empty;
        ent_t head;
        #1;
        stall     = (wait_cnt == SL);
        ready     = q.size() < 2;
        pre_empty = q.size() == 0;
        check("mem_ready", mem_ready, ready);
        check("alu_stall", alu_stall, stall);
        check("hazard_1", hazard_1, pend[chk_addr_1]);
        check("hazard_2", hazard_2, pend[chk_addr_2]);
        check("RegWrite", RegWrite, exp_rw);
        if (exp_rw) begin
            check("Write_addr", Write_addr, exp_wa);
            check("Write_data", Write_data, exp_wd);
        end
        acc  = alu_valid && !stall;
        pop  = !pre_empty && !acc;
        head = pre_empty ? '{a: 5'd0, d: '0} : q[0];
        exp_rw = 1'b0;
        if (acc && alu_addr != 0) begin
            exp_rw = 1'b1;
            exp_wa = alu_addr;
            exp_wd = alu_data;
        end else if (pop && head.a != 0) begin
            exp_rw = 1'b1;
            exp_wa = head.a;
            exp_wd = head.d;
        end
        if (pop) begin
            void'(q.pop_front());
            pend[head.a] = 1'b0;
        end
        if (mem_valid && ready) q.push_back('{a: mem_addr, d: mem_data});
        if (issue_valid && issue_addr != 0) pend[issue_addr] = 1'b1;
        wait_cnt = (pre_empty || pop) ? 0 : wait_cnt + 1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_RegWrite"}, RegWrite, 0);
        check({tag, "_Write_addr"}, Write_addr, 0);
        check({tag, "_Write_data"}, Write_data, 0);
        check({tag, "_mem_ready"}, mem_ready, 1);
        check({tag, "_alu_stall"}, alu_stall, 0);
        check({tag, "_hazard_1"}, hazard_1, 0);
        check({tag, "_hazard_2"}, hazard_2, 0);
    endtask

    initial begin
        idle();
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        issue_addr = '0; chk_addr_1 = '0; chk_addr_2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("init");
        rst = 1'b1;
        step();

        // ALU-only write appears one cycle later.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        step();
        idle();
        check("alu_we", RegWrite, 1);
        check("alu_addr", Write_addr, 5);
        check("alu_data", Write_data, 32'h1234);

        // Mem-only write appears two cycles later.
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hAA;
        step();
        idle();
        check("mem_we_n1", RegWrite, 0);
        step();
        check("mem_we_n2", RegWrite, 1);
        check("mem_addr", Write_addr, 7);
        check("mem_data", Write_data, 32'hAA);

        // ALU busy: FIFO fills, then the starved head is forced out.
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h100;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
        step();
        mem_addr = 5'd4; mem_data = 32'h44;
        step();
        check("full_ready", mem_ready, 0);
        mem_addr = 5'd6; mem_data = 32'h66;
        step();
        mem_valid = 1'b0;
        step();
        check("stall_early", alu_stall, 0);
        step();
        check("stall_hit", alu_stall, 1);
        step();
        check("starve_we", RegWrite, 1);
        check("starve_addr", Write_addr, 3);
        check("starve_data", Write_data, 32'h33);
        step();
        check("resume_stall", alu_stall, 0);
        check("resume_addr", Write_addr, 10);
        alu_valid = 1'b0;
        step();
        check("drain_addr", Write_addr, 4);
        step();

        // Pending-load scoreboard on register 9.
        chk_addr_1 = 5'd9; chk_addr_2 = 5'd8;
        issue_valid = 1'b1; issue_addr = 5'd9;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
        #1 check("haz_no_fwd", hazard_1, 0);
        step();
        check("haz_set", hazard_1, 1);
        mem_valid = 1'b0;
        step();
        check("haz_set_wins", hazard_1, 1);
        check("haz_pop9_we", Write_addr, 9);
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_data = 32'h98;
        step();
        check("haz_hold", hazard_1, 1);
        mem_valid = 1'b0;
        step();
        check("haz_clear", hazard_1, 0);
        check("haz_other", hazard_2, 0);

        // Writes to r0 from both sources are dropped; FIFO still drains.
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5;
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h6;
        step();
        check("r0_alu", RegWrite, 0);
        alu_valid = 1'b0;
        mem_addr = 5'd12; mem_data = 32'hC;
        step();
        check("r0_mem", RegWrite, 0);
        mem_valid = 1'b0;
        step();
        check("r0_drain_we", RegWrite, 1);
        check("r0_drain_addr", Write_addr, 12);
        check("r0_drain_ready", mem_ready, 1);

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end
        idle();
        repeat (4) step();

        // Reset asserted mid-burst with the FIFO full.
        chk_addr_1 = 5'd13;
        alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hB;
        mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 32'hD;
        issue_valid = 1'b1; issue_addr = 5'd13;
        step();
        mem_addr = 5'd14; mem_data = 32'hE;
        step();
        check("pre_rst_ready", mem_ready, 0);
        check("pre_rst_haz", hazard_1, 1);
        #2 rst = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        check("post_rst_we", RegWrite, 0);
        for (int i = 0; i < 50; i++) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
